// File: rtl/dpll_pkg.sv
// Shared types and default constants for the DPLL loop-bandwidth scheduler.
package dpll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACQ    = 2'd2,
    ST_LOCK   = 2'd3
  } dpll_state_e;

  localparam int K_W_DEF   = 4;
  localparam int K_MIN_DEF = 3;
  localparam int K_MAX_DEF = 15;
  localparam int WIN_W_DEF = 8;

endpackage

// File: rtl/dpll_gear_ctrl_if.sv
// Loop-filter side bundle: add/sub pulses and enable in, modulus/reset/lock status out.
interface dpll_gear_ctrl_if
  import dpll_pkg::*;
#(
  parameter int K_W = K_W_DEF
);
  logic           en;
  logic           add;
  logic           sub;
  logic [K_W-1:0] peak;
  logic           loop_rst;
  logic           gear_chg;
  logic           locked;
  dpll_state_e    state_o;

  modport master (
    output en, add, sub,
    input  peak, loop_rst, gear_chg, locked, state_o
  );

  modport slave (
    input  en, add, sub,
    output peak, loop_rst, gear_chg, locked, state_o
  );
endinterface

// File: rtl/dpll_win_meter.sv
// Fixed-length measurement window with a saturating add/sub event counter.
module dpll_win_meter #(
  parameter int WIN_W = 8
) (
  input  logic         clk_2,
  input  logic         rst,
  input  logic         clr,
  input  logic         add,
  input  logic         sub,
  output logic         win_end,
  output logic [WIN_W:0] ev_cnt
);

  logic [WIN_W-1:0] win_cnt_p1;
  logic [WIN_W:0]   ev_acc_p1;
  logic             ev_p0;

  function automatic logic [WIN_W:0] sat_inc(input logic [WIN_W:0] v, input logic inc);
    if (inc && (v != '1)) return v + {{WIN_W{1'b0}}, 1'b1};
    return v;
  endfunction

  // coincident add and sub are a single correction event
  assign ev_p0   = add | sub;
  assign win_end = (win_cnt_p1 == '1);
  // ev_cnt already includes this cycle's event so win_end sees the full window
  assign ev_cnt  = sat_inc(ev_acc_p1, ev_p0);

  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      win_cnt_p1 <= '0;
      ev_acc_p1  <= '0;
    end else if (clr) begin
      win_cnt_p1 <= '0;
      ev_acc_p1  <= '0;
    end else begin
      win_cnt_p1 <= win_cnt_p1 + {{(WIN_W-1){1'b0}}, 1'b1};
      ev_acc_p1  <= win_end ? '0 : ev_cnt;
    end
  end

endmodule

// File: rtl/dpll_gear_ctrl.sv
// DPLL K-counter bandwidth scheduler: acquires at K_MIN, gears up on quiet windows, locks at K_MAX.
module dpll_gear_ctrl
  import dpll_pkg::*;
#(
  parameter int K_W        = K_W_DEF,
  parameter int K_MIN      = K_MIN_DEF,
  parameter int K_MAX      = K_MAX_DEF,
  parameter int WIN_W      = WIN_W_DEF,
  parameter int LOCK_THR   = 2,
  parameter int LOCK_WINS  = 4,
  parameter int UNLOCK_THR = 8
) (
  input logic            clk_2,
  input logic            rst,
  dpll_gear_ctrl_if.slave bus
);

  localparam int EV_W = WIN_W + 1;
  localparam int QW   = $clog2(LOCK_WINS + 1);

  localparam logic [K_W-1:0]  K_MIN_C      = K_W'(K_MIN);
  localparam logic [K_W-1:0]  K_MAX_C      = K_W'(K_MAX);
  localparam logic [EV_W-1:0] LOCK_THR_C   = EV_W'(LOCK_THR);
  localparam logic [EV_W-1:0] UNLOCK_THR_C = EV_W'(UNLOCK_THR);
  localparam logic [QW-1:0]   LOCK_WINS_C  = QW'(LOCK_WINS);

  dpll_state_e     state_q, state_d;
  logic [K_W-1:0]  peak_p0, peak_p1;
  logic            locked_p0, locked_p1;
  logic            loop_rst_p0, loop_rst_p1;
  logic            gear_chg_p0, gear_chg_p1;
  logic [QW-1:0]   quiet_p0, quiet_p1, quiet_inc;
  logic            meter_clr;
  logic            win_end;
  logic [EV_W-1:0] ev_cnt;
  logic            win_quiet;
  logic            win_noisy;

  // next modulus (k<<1)|1, clipped to K_MAX; computed one bit wider to catch overflow
  function automatic logic [K_W-1:0] gear_up(input logic [K_W-1:0] k);
    logic [K_W:0] wide;
    wide = {k, 1'b1};
    if (wide > {1'b0, K_MAX_C}) return K_MAX_C;
    return wide[K_W-1:0];
  endfunction

  assign quiet_inc = quiet_p1 + 1'b1;
  assign win_quiet = (ev_cnt <= LOCK_THR_C);
  assign win_noisy = (ev_cnt >= UNLOCK_THR_C);
  // counters idle at zero in IDLE and restart on every state entry
  assign meter_clr = (state_q == ST_IDLE) || (state_d != state_q);

  dpll_win_meter #(
    .WIN_W (WIN_W)
  ) u_meter (
    .clk_2   (clk_2),
    .rst     (rst),
    .clr     (meter_clr),
    .add     (bus.add),
    .sub     (bus.sub),
    .win_end (win_end),
    .ev_cnt  (ev_cnt)
  );

  always_comb begin
    state_d     = state_q;
    peak_p0     = peak_p1;
    locked_p0   = locked_p1;
    quiet_p0    = quiet_p1;
    loop_rst_p0 = 1'b0;
    gear_chg_p0 = 1'b0;
    if (!bus.en) begin
      state_d   = ST_IDLE;
      peak_p0   = K_MIN_C;
      locked_p0 = 1'b0;
      quiet_p0  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_SETTLE;
          peak_p0     = K_MIN_C;
          locked_p0   = 1'b0;
          loop_rst_p0 = 1'b1;
        end
        ST_SETTLE: begin
          quiet_p0 = '0;
          if (win_end) state_d = ST_ACQ;
        end
        ST_ACQ: begin
          if (win_end) begin
            if (!win_quiet) begin
              quiet_p0 = '0;
            end else if (quiet_inc < LOCK_WINS_C) begin
              quiet_p0 = quiet_inc;
            end else begin
              quiet_p0 = '0;
              if (peak_p1 < K_MAX_C) begin
                peak_p0     = gear_up(peak_p1);
                gear_chg_p0 = 1'b1;
                loop_rst_p0 = 1'b1;
                state_d     = ST_SETTLE;
              end else begin
                locked_p0 = 1'b1;
                state_d   = ST_LOCK;
              end
            end
          end
        end
        ST_LOCK: begin
          if (win_end && win_noisy) begin
            locked_p0   = 1'b0;
            peak_p0     = K_MIN_C;
            gear_chg_p0 = 1'b1;
            loop_rst_p0 = 1'b1;
            state_d     = ST_SETTLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // decision -> registered outputs
  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      peak_p1     <= K_MIN_C;
      locked_p1   <= 1'b0;
      loop_rst_p1 <= 1'b0;
      gear_chg_p1 <= 1'b0;
      quiet_p1    <= '0;
    end else begin
      state_q     <= state_d;
      peak_p1     <= peak_p0;
      locked_p1   <= locked_p0;
      loop_rst_p1 <= loop_rst_p0;
      gear_chg_p1 <= gear_chg_p0;
      quiet_p1    <= quiet_p0;
    end
  end

  assign bus.peak     = peak_p1;
  assign bus.locked   = locked_p1;
  assign bus.loop_rst = loop_rst_p1;
  assign bus.gear_chg = gear_chg_p1;
  assign bus.state_o  = state_q;

endmodule
